fetch_sequencer: RTL and testbench

Fetch/execute sequencer for the 12-bit-address core. It owns instruction-fetch handshaking with instruction memory and gates when `program_counter` is allowed to update. The PC advances only on `pc_enable`; branch/jump selection stays in the PC and decoder. It sits between `program_counter`, the instruction memory port and the execute stage.

---
 rtl/fetch_sequencer_pkg.sv | 12 +
 rtl/fetch_timeout_counter.sv | 29 ++
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch/execute sequencer of the 12-bit-address core.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_WAIT = 3'd2,
    EXECUTE    = 3'd3,
    HALTED     = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts wait cycles for an outstanding fetch; expired is high once the count reaches TIMEOUT.
module fetch_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Saturates at TIMEOUT so a stuck enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: drives the instruction-memory handshake and strobes pc_enable on retire.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int I_ADDR_W = 12,
  parameter int INSTR_W  = 16,
  parameter int TIMEOUT  = 15,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                halt_request,
  input  logic [I_ADDR_W-1:0] pc,
  output logic                imem_req,
  output logic [I_ADDR_W-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [INSTR_W-1:0]  instr,
  output logic                instr_valid,
  input  logic                exec_done,
  output logic                pc_enable,
  output logic [2:0]          state,
  output logic                halted,
  output logic                fetch_error,
  output logic [COUNT_W-1:0]  retired_count
);

  // Handshake: a fetch is accepted on a cycle where imem_req && imem_ready; the
  // response is the first cycle afterwards with imem_rvalid; an instruction
  // retires on the cycle where instr_valid && exec_done.

  fetch_state_e state_q, state_d;
  logic         wait_clear, wait_enable, wait_expired;
  logic         load_instr, set_error, retire;

  fetch_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wait_clear),
    .enable (wait_enable),
    .expired(wait_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_clear  = 1'b1;
    wait_enable = 1'b0;
    load_instr  = 1'b0;
    set_error   = 1'b0;
    retire      = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt_request) state_d = HALTED;
        else if (run)     state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (imem_ready) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        // The counter is held clear everywhere else, so it starts at 0 on entry.
        wait_clear = 1'b0;
        if (imem_rvalid) begin
          load_instr = 1'b1;
          state_d    = EXECUTE;
        end else if (wait_expired) begin
          set_error = 1'b1;
          state_d   = HALTED;
        end else begin
          wait_enable = 1'b1;
        end
      end
      EXECUTE: begin
        if (exec_done) begin
          retire  = 1'b1;
          state_d = halt_request ? HALTED : FETCH_REQ;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr         <= '0;
      fetch_error   <= 1'b0;
      retired_count <= '0;
    end else begin
      if (load_instr) instr <= imem_rdata;
      if (set_error)  fetch_error <= 1'b1;
      if (retire)     retired_count <= retired_count + 1'b1;
    end
  end

  assign imem_req    = (state_q == FETCH_REQ);
  assign imem_addr   = imem_req ? pc : '0;
  assign instr_valid = (state_q == EXECUTE);
  assign halted      = (state_q == HALTED);
  assign pc_enable   = retire;
  assign state       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: bench-side PC model plus an expected-instruction queue.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int I_ADDR_W = 12;
  localparam int INSTR_W  = 16;
  localparam int TIMEOUT  = 4;
  localparam int COUNT_W  = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                run;
  logic                halt_request;
  logic [I_ADDR_W-1:0] pc;
  logic                imem_req;
  logic [I_ADDR_W-1:0] imem_addr;
  logic                imem_ready;
  logic                imem_rvalid;
  logic [INSTR_W-1:0]  imem_rdata;
  logic [INSTR_W-1:0]  instr;
  logic                instr_valid;
  logic                exec_done;
  logic                pc_enable;
  logic [2:0]          state;
  logic                halted;
  logic                fetch_error;
  logic [COUNT_W-1:0]  retired_count;

  int                  n_checks = 0;
  int                  n_pass   = 0;
  logic [INSTR_W-1:0]  exp_q[$];
  logic [COUNT_W-1:0]  exp_retired;

  fetch_sequencer #(
    .I_ADDR_W(I_ADDR_W),
    .INSTR_W (INSTR_W),
    .TIMEOUT (TIMEOUT),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .halt_request (halt_request),
    .pc           (pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .pc_enable    (pc_enable),
    .state        (state),
    .halted       (halted),
    .fetch_error  (fetch_error),
    .retired_count(retired_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"},   32'(state), 32'(IDLE));
    check({tag, "_req"},     32'(imem_req), 0);
    check({tag, "_addr"},    32'(imem_addr), 0);
    check({tag, "_instr"},   32'(instr), 0);
    check({tag, "_ivalid"},  32'(instr_valid), 0);
    check({tag, "_pcen"},    32'(pc_enable), 0);
    check({tag, "_halted"},  32'(halted), 0);
    check({tag, "_ferr"},    32'(fetch_error), 0);
    check({tag, "_retired"}, 32'(retired_count), 0);
  endtask

  // All driver tasks start and end at a falling edge.
  task automatic reset_dut();
    rst_n        = 1'b0;
    run          = 1'b0;
    halt_request = 1'b0;
    imem_ready   = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    exec_done    = 1'b0;
    pc           = '0;
    exp_q.delete();
    exp_retired  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_reset_state("reset");
    @(negedge clk);
  endtask

  task automatic start_run();
    run = 1'b1;
    #1 check("run_idle_state", 32'(state), 32'(IDLE));
    @(negedge clk);
    run = 1'b0;
  endtask

  // One instruction from FETCH_REQ to retire, with the given wait/back-pressure delays.
  task automatic run_instr(input int rdy_dly, input int rv_dly, input logic [INSTR_W-1:0] data,
                           input int ex_dly, input bit hlt);
    logic [I_ADDR_W-1:0] a;
    a = pc;
    for (int i = 0; i <= rdy_dly; i++) begin
      imem_ready   = (i == rdy_dly);
      exec_done    = 1'b1;
      imem_rvalid  = 1'($urandom_range(0, 1));
      halt_request = hlt;
      #1;
      check("req_state", 32'(state), 32'(FETCH_REQ));
      check("req_valid", 32'(imem_req), 1);
      check("req_addr",  32'(imem_addr), 32'(a));
      check("req_pcen",  32'(pc_enable), 0);
      @(negedge clk);
    end
    imem_ready = 1'b0;
    exp_q.push_back(data);
    for (int j = 0; j <= rv_dly; j++) begin
      imem_rvalid = (j == rv_dly);
      imem_rdata  = (j == rv_dly) ? data : INSTR_W'($urandom);
      exec_done   = 1'($urandom_range(0, 1));
      #1;
      check("wait_state",  32'(state), 32'(FETCH_WAIT));
      check("wait_req",    32'(imem_req), 0);
      check("wait_ivalid", 32'(instr_valid), 0);
      check("wait_pcen",   32'(pc_enable), 0);
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    for (int k = 0; k <= ex_dly; k++) begin
      exec_done  = (k == ex_dly);
      imem_ready = 1'($urandom_range(0, 1));
      #1;
      check("exec_state",  32'(state), 32'(EXECUTE));
      check("exec_ivalid", 32'(instr_valid), 1);
      check("exec_instr",  32'(instr), 32'(exp_q[0]));
      check("exec_pcen",   32'(pc_enable), (k == ex_dly) ? 1 : 0);
      if (k == ex_dly) begin
        void'(exp_q.pop_front());
        exp_retired = exp_retired + 1'b1;
      end
      @(negedge clk);
    end
    exec_done    = 1'b0;
    imem_ready   = 1'b0;
    halt_request = 1'b0;
    pc           = pc + 1'b1;
    check("retire_count", 32'(retired_count), 32'(exp_retired));
    check("retire_state", 32'(state), hlt ? 32'(HALTED) : 32'(FETCH_REQ));
  endtask

  initial begin
    reset_dut();

    // basic fetch at pc 0, then the next fetch must present pc 1
    start_run();
    run_instr(0, 0, 16'hA5C3, 0, 1'b0);
    check("basic_retired", 32'(retired_count), 1);
    // back-pressure: 4 cycles not ready, response 3 cycles later
    run_instr(4, 3, 16'h5A3C, 2, 1'b0);
    for (int r = 0; r < 6; r++)
      run_instr($urandom_range(0, 3), $urandom_range(0, TIMEOUT), INSTR_W'($urandom),
                $urandom_range(0, 3), 1'b0);

    // halt requested during the fetch: instruction still retires, then HALTED
    run_instr(0, 2, 16'h1234, 1, 1'b1);
    for (int h = 0; h < 3; h++) begin
      run       = 1'b1;
      exec_done = 1'b1;
      #1;
      check("halted_state", 32'(state), 32'(HALTED));
      check("halted_flag",  32'(halted), 1);
      check("halted_req",   32'(imem_req), 0);
      check("halted_pcen",  32'(pc_enable), 0);
      @(negedge clk);
    end
    run       = 1'b0;
    exec_done = 1'b0;

    // halt_request beats run in IDLE
    reset_dut();
    run          = 1'b1;
    halt_request = 1'b1;
    #1 check("idle_halt_req", 32'(imem_req), 0);
    @(negedge clk);
    run          = 1'b0;
    halt_request = 1'b0;
    #1;
    check("idle_halt_state", 32'(state), 32'(HALTED));
    check("idle_halt_req2",  32'(imem_req), 0);
    @(negedge clk);

    // fetch timeout: TIMEOUT+1 cycles in FETCH_WAIT, then sticky error
    reset_dut();
    start_run();
    imem_ready = 1'b1;
    #1 check("to_req_state", 32'(state), 32'(FETCH_REQ));
    @(negedge clk);
    imem_ready = 1'b0;
    for (int j = 0; j <= TIMEOUT; j++) begin
      #1;
      check("to_wait_state", 32'(state), 32'(FETCH_WAIT));
      check("to_wait_ferr",  32'(fetch_error), 0);
      check("to_wait_pcen",  32'(pc_enable), 0);
      @(negedge clk);
    end
    #1;
    check("to_state",  32'(state), 32'(HALTED));
    check("to_ferr",   32'(fetch_error), 1);
    check("to_halted", 32'(halted), 1);
    imem_rvalid = 1'b1;
    imem_rdata  = 16'hBEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    check("to_late_state", 32'(state), 32'(HALTED));
    check("to_late_instr", 32'(instr), 0);
    check("to_late_ferr",  32'(fetch_error), 1);
    @(negedge clk);

    // reset clears the sticky error; then 17 retires at full rate wrap a 4-bit counter
    reset_dut();
    start_run();
    for (int w = 0; w < 17; w++)
      run_instr(0, 0, INSTR_W'($urandom), 0, 1'b0);
    check("wrap_count", 32'(retired_count), 1);

    // reset while a fetch is outstanding; the late response is ignored
    imem_ready = 1'b1;
    #1;
    @(negedge clk);
    imem_ready = 1'b0;
    #1 check("mid_wait_state", 32'(state), 32'(FETCH_WAIT));
    rst_n = 1'b0;
    #1;
    check("mid_rst_state",   32'(state), 32'(IDLE));
    check("mid_rst_instr",   32'(instr), 0);
    check("mid_rst_retired", 32'(retired_count), 0);
    check("mid_rst_ferr",    32'(fetch_error), 0);
    @(negedge clk);
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 16'hC0DE;
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    check("mid_late_state", 32'(state), 32'(IDLE));
    check("mid_late_instr", 32'(instr), 0);
    check("mid_late_req",   32'(imem_req), 0);
    check("queue_empty",    32'(exp_q.size()), 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
